// File: rtl/ccm_ctr_unpad_pkg.sv
// Shared definitions for the CCM counter-mode unpadding path.
// Provides the FSM state encoding, AES block size and padded frame size.
package ccm_pkg;

    localparam int AES_BLOCK_BYTES = 16;

    typedef enum logic [1:0] {
        CCM_IDLE = 2'd0,
        CCM_KEEP = 2'd1,
        CCM_DROP = 2'd2
    } ccm_state_e;

    // Upstream always emits whole blocks, plus a full pad block when L is block aligned.
    function automatic logic [16:0] ccm_frame_bytes(input logic [15:0] len);
        logic [12:0] blocks;
        blocks = 13'(len >> 4) + 13'd1;
        return {blocks, 4'b0000};
    endfunction

endpackage

// File: rtl/ccm_ctr_unpad_if.sv
// Byte stream bundle between ccm_ctr, the unpadder and its consumer.
// The ovf signal exists only when CCM_UNPAD_OVF_FLAG_EN is defined.
interface ccm_ctr_unpad_if #(
    parameter int WIDTH     = 8,
    parameter int WIDTH_LEN = 8
);
    logic [WIDTH-1:0]     in_data;
    logic                 in_en;
    logic [WIDTH_LEN-1:0] data_length;
    logic [WIDTH-1:0]     out_data;
    logic                 out_en;
    logic                 out_last;
    logic                 out_ready;
    logic                 frame_done;
`ifdef CCM_UNPAD_OVF_FLAG_EN
    logic                 ovf;
`endif

    modport slave (
        input  in_data, in_en, data_length, out_ready,
        output out_data, out_en, out_last, frame_done
`ifdef CCM_UNPAD_OVF_FLAG_EN
        , output ovf
`endif
    );

    modport master (
        output in_data, in_en, data_length, out_ready,
        input  out_data, out_en, out_last, frame_done
`ifdef CCM_UNPAD_OVF_FLAG_EN
        , input ovf
`endif
    );

endinterface

// File: rtl/ccm_ctr_unpad_fifo.sv
// Show-ahead synchronous FIFO; the extra pointer MSB separates full from empty.
// A write while full is accepted only when a read frees a slot in the same cycle.
module ccm_sync_fifo #(
    parameter int DW    = 9,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          full,
    output logic          empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0]   wr_ptr_reg;
    logic [AW:0]   rd_ptr_reg;
    logic [DW-1:0] mem_reg [DEPTH];
    logic          do_rd;
    logic          do_wr;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign do_rd   = rd_en & ~empty;
    assign do_wr   = wr_en & (~full | do_rd);
    assign rd_data = mem_reg[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_wr) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (do_rd) rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
        end else if (do_wr) begin
            mem_reg[wr_ptr_reg[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/ccm_ctr_unpad.sv
// Strips ccm_ctr zero padding, tags the final payload byte and buffers output.
// Define CCM_UNPAD_OVF_FLAG_EN to add the sticky ovf flag for dropped bytes.
module ccm_ctr_unpad
    import ccm_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int WIDTH_LEN  = 8,
    parameter int FIFO_DEPTH = AES_BLOCK_BYTES
) (
    input logic            clk,
    input logic            reset,
    ccm_ctr_unpad_if.slave bus
);
    localparam int TW = WIDTH_LEN + 1;
    localparam logic [1:0] S_IDLE = CCM_IDLE;
    localparam logic [1:0] S_KEEP = CCM_KEEP;
    localparam logic [1:0] S_DROP = CCM_DROP;

    logic [1:0]           state_reg, state_next;
    logic [TW-1:0]        cnt_reg, cnt_next;
    logic [TW-1:0]        total_reg, total_next;
    logic [WIDTH_LEN-1:0] len_reg, len_next;
    logic                 frame_done_reg, frame_done_next;

    logic [TW-1:0]        total_in;
    logic [TW-1:0]        cnt_inc;
    logic [TW-1:0]        len_ext;
    logic                 push;
    logic                 push_last;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [WIDTH:0]       fifo_head;

    // In IDLE the incoming byte is byte 1 and the length comes straight from the port.
    assign total_in = TW'(ccm_frame_bytes(16'(bus.data_length)));
    assign cnt_inc  = (state_reg == S_IDLE) ? TW'(1) : cnt_reg + TW'(1);
    assign len_ext  = (state_reg == S_IDLE) ? TW'(bus.data_length) : TW'(len_reg);

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        total_next      = total_reg;
        len_next        = len_reg;
        frame_done_next = 1'b0;
        push            = 1'b0;
        push_last       = 1'b0;
        if (bus.in_en) begin
            cnt_next = cnt_inc;
            case (state_reg)
                S_IDLE: begin
                    len_next   = bus.data_length;
                    total_next = total_in;
                    if (bus.data_length == '0) begin
                        state_next = S_DROP;
                    end else begin
                        push       = 1'b1;
                        push_last  = (cnt_inc == len_ext);
                        state_next = push_last ? S_DROP : S_KEEP;
                    end
                end
                S_KEEP: begin
                    push      = 1'b1;
                    push_last = (cnt_inc == len_ext);
                    if (push_last) begin
                        if (cnt_inc == total_reg) begin
                            state_next      = S_IDLE;
                            frame_done_next = 1'b1;
                        end else begin
                            state_next = S_DROP;
                        end
                    end
                end
                S_DROP: begin
                    if (cnt_inc == total_reg) begin
                        state_next      = S_IDLE;
                        frame_done_next = 1'b1;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= '0;
            total_reg      <= '0;
            len_reg        <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            total_reg      <= total_next;
            len_reg        <= len_next;
            frame_done_reg <= frame_done_next;
        end
    end

    assign pop = bus.out_en & bus.out_ready;

    ccm_sync_fifo #(
        .DW    (WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push),
        .wr_data ({push_last, bus.in_data}),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign bus.out_data   = fifo_head[WIDTH-1:0];
    assign bus.out_en     = ~fifo_empty;
    assign bus.out_last   = fifo_head[WIDTH] & ~fifo_empty;
    assign bus.frame_done = frame_done_reg;

`ifdef CCM_UNPAD_OVF_FLAG_EN
    logic ovf_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_reg <= 1'b0;
        end else if (push & fifo_full & ~pop) begin
            ovf_reg <= 1'b1;
        end
    end

    assign bus.ovf = ovf_reg;
`endif

endmodule

// File: doc/ccm_ctr_unpad.md
# ccm_ctr_unpad

Byte-serial post-processor placed directly downstream of `ccm_ctr`. `ccm_ctr` emits encrypted bytes zero-padded to a whole number of 16-byte AES blocks. This block strips that padding, forwards only the first `data_length` bytes with a last-byte marker, and buffers them in a 16-entry FIFO so the consumer can apply backpressure.

## Interface
- `WIDTH`, 8: data byte width.
- `WIDTH_LEN`, 8: width of message length in bytes (max 255).
- `FIFO_DEPTH`, 16: output buffer entries (one AES block); power of two.

- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_data`  in  WIDTH  encrypted byte from `ccm_ctr` (`out_data`).
- `in_en`  in  1  byte valid from `ccm_ctr` (`out_en`); no backpressure upstream.
- `data_length`  in  WIDTH_LEN  plaintext length L in bytes; sampled on first `in_en` of a frame.
- `out_data`  out  WIDTH  payload byte (FIFO head).
- `out_en`  out  1  `out_data` valid (FIFO non-empty).
- `out_last`  out  1  high with the final payload byte of a frame.
- `out_ready`  in  1  consumer accepts; a transfer occurs when `out_en & out_ready`.
- `frame_done`  out  1  one-cycle pulse after the final padded input byte of a frame is absorbed.
- `ovf`  out  1  sticky FIFO overflow flag (only with `CCM_UNPAD_OVF_FLAG_EN`).

## Operation
- Upstream frame size is fixed: T = 16·(⌊L/16⌋+1) bytes. A full pad block is emitted when L is a multiple of 16.
  - Compute T as `{(L>>4)+1, 4'b0}` at WIDTH_LEN+1 bits.
- FSM states:
  - IDLE → KEEP on `in_en`: latch L and T; byte counter := 1.
    - If L > 0, the byte is pushed.
    - If L == 0, go to DROP instead.
  - KEEP: each `in_en` pushes `in_data` with tag `last = (cnt == L)`. After the L-th byte, go to DROP, or to IDLE if the L-th byte is also byte T.
  - DROP: `in_en` bytes are counted and discarded. When the count reaches T, pulse `frame_done` and go to IDLE.
- `frame_done` also fires on the KEEP→IDLE direct path.
- `in_en` gaps inside a frame are legal; the counter only advances on `in_en`.
- FIFO:
  - Each entry stores WIDTH+1 bits (data, last).
  - Show-ahead read.
  - Read and write pointers are log2(FIFO_DEPTH)+1 bits, so full/empty is decided by the MSB compare.
- Push while full with no pop in the same cycle: the byte is dropped and `ovf` is set. The frame counter still advances, so framing stays aligned.
- Push while full with a pop in the same cycle: accepted.
- Push and pop on an empty FIFO: the push is written; the pop is ignored because `out_en` was low.

## Timing
- Reset values:
  - `out_en`=0, `out_last`=0, `out_data`=0, `frame_done`=0, `ovf`=0.
  - FSM in IDLE; pointers and counters 0.
- Latency: a byte with `in_en` high at edge k is visible on `out_data`/`out_en` after edge k (1 cycle) when the FIFO is empty.
- `out_last` is combinational from the FIFO head tag and valid only while `out_en`=1.
- `frame_done` is registered and goes high for the cycle after the edge that absorbs byte T.
- A new frame's first `in_en` may arrive on the cycle right after byte T. Back-to-back frames need no idle cycle.
- Asserting `reset` mid-frame clears the FIFO, the FSM and `ovf` immediately. Partial frames are lost.

## Configuration
- `CCM_UNPAD_OVF_FLAG_EN` defined:
  - `ovf` port present; set on the first dropped push.
  - Cleared only by reset.
- Not defined:
  - `ovf` port and register absent.
  - Overflowing bytes are silently dropped; all other behaviour is identical.

## Structure
- Shared package `ccm_pkg`:
  - FSM state enum (IDLE, KEEP, DROP).
  - Constant `AES_BLOCK_BYTES = 16`.
  - Function computing T from L.
- One sub-module: `ccm_sync_fifo` (parameterised WIDTH+1 × FIFO_DEPTH, show-ahead, full/empty).
- Top level holds the FSM and the counters.

## Test plan
- L=34, 48 contiguous bytes, `out_ready`=1 → 34 bytes out in order; `out_last` on byte 34; bytes 35–48 never appear; `frame_done` one cycle after the 48th input edge.
- L=32 → 48 bytes in (a full pad block), 32 out, `out_last` on byte 32.
- L=0 → 16 bytes in, `out_en` never asserts, `frame_done` pulses once.
- L=34 with `out_ready`=0 throughout → FIFO holds bytes 1–16, `ovf`=1 from the 17th kept byte. Raising `out_ready` then drains exactly 16 bytes with no `out_last`; `frame_done` still fires.
- Two frames back-to-back (L=5 then L=20, 16+32 bytes, no gap) → 5 bytes with last, then 20 bytes with last; two `frame_done` pulses.
- `reset` low at byte 10 of an L=34 frame, then a fresh L=3 frame → outputs at reset values immediately; only the 3 new bytes are output, with `out_last` on the 3rd.
